// File: rtl/ps2_text_entry.sv
// Purpose: PS/2 scan-code decoder and text cursor that drives one-cycle writes into the character RAM.
// Latency: wr_en/wr_addr/wr_data and cursor update on the edge that accepts a byte (visible next cycle).
// Backpressure: none on input; bytes presented while busy (clear sweep) or flagged by err are dropped.
module ps2_text_entry #(
    parameter int BUFFER_WIDTH  = 12,
    parameter int BUFFER_HEIGHT = 9,
    parameter int ADDR_WIDTH    = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  read_data,
    input  logic                  err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic [ADDR_WIDTH-1:0] cursor,
    output logic                  shift_active,
    output logic                  caps_lock,
    output logic                  busy
);
    localparam int NUM_CELLS = BUFFER_WIDTH * BUFFER_HEIGHT;
    localparam int CW = (BUFFER_WIDTH  > 1) ? $clog2(BUFFER_WIDTH)  : 1;
    localparam int RW = (BUFFER_HEIGHT > 1) ? $clog2(BUFFER_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(NUM_CELLS - 1);
    localparam logic [CW-1:0]         LAST_COL  = CW'(BUFFER_WIDTH - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(BUFFER_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

    dec_state_t      state, state_nxt;
    logic            make_evt, break_evt;
    logic            lshift, rshift, caps_held;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            is_print;
    logic [7:0]      lo_char, hi_char, ascii;

    assign shift_active = lshift | rshift;

    // Decoder state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Decoder next state: classify each accepted byte as make, break or prefix
    always_comb begin
        state_nxt = state;
        make_evt  = 1'b0;
        break_evt = 1'b0;
        if (read_data && !busy) begin
            if (err) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_data == 8'hF0)      state_nxt = BRK;
                        else if (rx_data == 8'hE0) state_nxt = EXT;
                        else                       make_evt  = 1'b1;
                    end
                    BRK: begin
                        break_evt = 1'b1;
                        state_nxt = IDLE;
                    end
                    EXT:     state_nxt = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
                    EXT_BRK: state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Scan code to ASCII; letters take case from shift XOR caps, the rest from shift only
    always_comb begin
        is_print = 1'b1;
        lo_char  = 8'h00;
        hi_char  = 8'h00;
        case (rx_data)
            8'h1C: lo_char = "a";  8'h32: lo_char = "b";  8'h21: lo_char = "c";
            8'h23: lo_char = "d";  8'h24: lo_char = "e";  8'h2B: lo_char = "f";
            8'h34: lo_char = "g";  8'h33: lo_char = "h";  8'h43: lo_char = "i";
            8'h3B: lo_char = "j";  8'h42: lo_char = "k";  8'h4B: lo_char = "l";
            8'h3A: lo_char = "m";  8'h31: lo_char = "n";  8'h44: lo_char = "o";
            8'h4D: lo_char = "p";  8'h15: lo_char = "q";  8'h2D: lo_char = "r";
            8'h1B: lo_char = "s";  8'h2C: lo_char = "t";  8'h3C: lo_char = "u";
            8'h2A: lo_char = "v";  8'h1D: lo_char = "w";  8'h22: lo_char = "x";
            8'h35: lo_char = "y";  8'h1A: lo_char = "z";
            8'h45: begin lo_char = "0"; hi_char = ")"; end
            8'h16: begin lo_char = "1"; hi_char = "!"; end
            8'h1E: begin lo_char = "2"; hi_char = "@"; end
            8'h26: begin lo_char = "3"; hi_char = "#"; end
            8'h25: begin lo_char = "4"; hi_char = "$"; end
            8'h2E: begin lo_char = "5"; hi_char = "%"; end
            8'h36: begin lo_char = "6"; hi_char = "^"; end
            8'h3D: begin lo_char = "7"; hi_char = "&"; end
            8'h3E: begin lo_char = "8"; hi_char = "*"; end
            8'h46: begin lo_char = "9"; hi_char = "("; end
            8'h29: begin lo_char = " "; hi_char = " "; end
            8'h4E: begin lo_char = "-"; hi_char = "_"; end
            8'h55: begin lo_char = "="; hi_char = "+"; end
            8'h41: begin lo_char = ","; hi_char = "<"; end
            8'h49: begin lo_char = "."; hi_char = ">"; end
            8'h4A: begin lo_char = "/"; hi_char = "?"; end
            default: is_print = 1'b0;
        endcase
        if (lo_char >= 8'h61 && lo_char <= 8'h7A)
            ascii = (shift_active ^ caps_lock) ? (lo_char - 8'h20) : lo_char;
        else
            ascii = shift_active ? hi_char : lo_char;
    end

    // Modifier tracking; caps_held blocks typematic repeats from re-toggling caps lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_held <= 1'b0;
            caps_lock <= 1'b0;
        end else if (make_evt) begin
            if (rx_data == 8'h12) lshift <= 1'b1;
            if (rx_data == 8'h59) rshift <= 1'b1;
            if (rx_data == 8'h58) begin
                if (!caps_held) caps_lock <= ~caps_lock;
                caps_held <= 1'b1;
            end
        end else if (break_evt) begin
            if (rx_data == 8'h12) lshift    <= 1'b0;
            if (rx_data == 8'h59) rshift    <= 1'b0;
            if (rx_data == 8'h58) caps_held <= 1'b0;
        end
    end

    // Cursor movement, write strobes and the clear-screen sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            cursor  <= '0;
            col     <= '0;
            row     <= '0;
            busy    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (busy) begin
                // Sweep walks wr_addr itself; wr_data stays at space throughout
                if (wr_addr == LAST_CELL) begin
                    busy   <= 1'b0;
                    cursor <= '0;
                    col    <= '0;
                    row    <= '0;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= wr_addr + 1'b1;
                end
            end else if (make_evt) begin
                if (rx_data == 8'h76) begin
                    busy    <= 1'b1;
                    wr_en   <= 1'b1;
                    wr_addr <= '0;
                    wr_data <= 8'h20;
                end else if (rx_data == 8'h66) begin
                    if (cursor != '0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cursor - 1'b1;
                        wr_data <= 8'h20;
                        cursor  <= cursor - 1'b1;
                        if (col == '0) begin
                            col <= LAST_COL;
                            row <= row - 1'b1;
                        end else begin
                            col <= col - 1'b1;
                        end
                    end
                end else if (rx_data == 8'h5A) begin
                    col <= '0;
                    if (row == LAST_ROW) begin
                        row    <= '0;
                        cursor <= '0;
                    end else begin
                        row    <= row + 1'b1;
                        cursor <= cursor + ADDR_WIDTH'(BUFFER_WIDTH) - ADDR_WIDTH'(col);
                    end
                end else if (is_print) begin
                    wr_en   <= 1'b1;
                    wr_addr <= cursor;
                    wr_data <= ascii;
                    if (cursor == LAST_CELL) begin
                        cursor <= '0;
                        col    <= '0;
                        row    <= '0;
                    end else begin
                        cursor <= cursor + 1'b1;
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_text_entry.sv
// Purpose: directed bench for ps2_text_entry covering decode, modifiers, cursor and clear sweep.
// Latency: each byte is held for one cycle; results are sampled on the following falling edge.
// Backpressure: none; bytes injected during the clear sweep are expected to be dropped.
module tb_ps2_text_entry;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       read_data = 1'b0;
    logic       err = 1'b0;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] cursor;
    logic       shift_active;
    logic       caps_lock;
    logic       busy;

    int errors = 0;
    int checks = 0;

    ps2_text_entry #(.BUFFER_WIDTH(12), .BUFFER_HEIGHT(9), .ADDR_WIDTH(7)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data), .err(err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cursor(cursor),
        .shift_active(shift_active), .caps_lock(caps_lock), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present one byte for one cycle; returns on the falling edge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input logic e = 1'b0);
        @(negedge clk);
        rx_data   = b;
        err       = e;
        read_data = 1'b1;
        @(negedge clk);
        read_data = 1'b0;
        err       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, cursor, shift_active, caps_lock, busy} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h cur=%0d sh=%b caps=%b busy=%b, need all 0",
                     wr_en, wr_addr, wr_data, cursor, shift_active, caps_lock, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_addr, wr_data, cursor} !== {1'b1, 7'd0, 8'h61, 7'd1}) begin
            errors++;
            $display("FAIL basic_make: got en=%b addr=%0d data=%h cur=%0d, need 1/0/61/1", wr_en, wr_addr, wr_data, cursor);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if ({wr_en, cursor, wr_data} !== {1'b0, 7'd1, 8'h61}) begin
            errors++;
            $display("FAIL basic_break: got en=%b cur=%0d data=%h, need 0/1/61 held", wr_en, cursor, wr_data);
        end
    endtask

    task automatic test_shift();
        do_reset();
        send_byte(8'h12);
        checks++;
        if ({shift_active, wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL shift_make: got sh=%b en=%b, need 1/0", shift_active, wr_en);
        end
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 7'd0, 8'h41}) begin
            errors++;
            $display("FAIL shift_upper: got en=%b addr=%0d data=%h, need 1/0/41", wr_en, wr_addr, wr_data);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        checks++;
        if (shift_active !== 1'b1) begin
            errors++;
            $display("FAIL shift_pending_break: got sh=%b, need 1", shift_active);
        end
        send_byte(8'h12);
        checks++;
        if (shift_active !== 1'b0) begin
            errors++;
            $display("FAIL shift_release: got sh=%b, need 0", shift_active);
        end
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 7'd1, 8'h61}) begin
            errors++;
            $display("FAIL shift_lower: got en=%b addr=%0d data=%h, need 1/1/61", wr_en, wr_addr, wr_data);
        end
        send_byte(8'h59);
        send_byte(8'h16);
        checks++;
        if ({shift_active, wr_data} !== {1'b1, 8'h21}) begin
            errors++;
            $display("FAIL rshift_digit: got sh=%b data=%h, need 1/21", shift_active, wr_data);
        end
    endtask

    task automatic test_caps();
        do_reset();
        send_byte(8'h58);
        send_byte(8'h58);
        send_byte(8'h58);
        checks++;
        if (caps_lock !== 1'b1) begin
            errors++;
            $display("FAIL caps_typematic: got caps=%b, need 1", caps_lock);
        end
        send_byte(8'hF0);
        send_byte(8'h58);
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_data, caps_lock} !== {1'b1, 8'h41, 1'b1}) begin
            errors++;
            $display("FAIL caps_upper: got en=%b data=%h caps=%b, need 1/41/1", wr_en, wr_data, caps_lock);
        end
        send_byte(8'h12);
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_data} !== {1'b1, 8'h61}) begin
            errors++;
            $display("FAIL caps_shift_lower: got en=%b data=%h, need 1/61", wr_en, wr_data);
        end
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1E);
        checks++;
        if (wr_data !== 8'h32) begin
            errors++;
            $display("FAIL caps_digit: got data=%h, need 32", wr_data);
        end
        send_byte(8'h58);
        checks++;
        if (caps_lock !== 1'b0) begin
            errors++;
            $display("FAIL caps_second_toggle: got caps=%b, need 0", caps_lock);
        end
    endtask

    task automatic test_decoder();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if ({wr_en, cursor} !== {1'b0, 7'd0}) begin
            errors++;
            $display("FAIL ext_ignored: got en=%b cur=%0d, need 0/0", wr_en, cursor);
        end
        send_byte(8'hF0, 1'b1);
        send_byte(8'h4A);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 7'd0, 8'h2F}) begin
            errors++;
            $display("FAIL err_drop: got en=%b addr=%0d data=%h, need 1/0/2F", wr_en, wr_addr, wr_data);
        end
        send_byte(8'h05);
        checks++;
        if ({wr_en, cursor} !== {1'b0, 7'd1}) begin
            errors++;
            $display("FAIL unlisted_code: got en=%b cur=%0d, need 0/1", wr_en, cursor);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 107; i++) send_byte(8'h1C);
        checks++;
        if (cursor !== 7'd107) begin
            errors++;
            $display("FAIL wrap_fill: got cur=%0d, need 107", cursor);
        end
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_addr, cursor} !== {1'b1, 7'd107, 7'd0}) begin
            errors++;
            $display("FAIL wrap_last: got en=%b addr=%0d cur=%0d, need 1/107/0", wr_en, wr_addr, cursor);
        end
        send_byte(8'h66);
        checks++;
        if ({wr_en, cursor} !== {1'b0, 7'd0}) begin
            errors++;
            $display("FAIL bksp_at_zero: got en=%b cur=%0d, need 0/0", wr_en, cursor);
        end
    endtask

    task automatic test_enter_bksp();
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_addr} !== {1'b1, 7'd1}) begin
            errors++;
            $display("FAIL second_addr: got en=%b addr=%0d, need 1/1", wr_en, wr_addr);
        end
        send_byte(8'h5A);
        checks++;
        if ({wr_en, cursor} !== {1'b0, 7'd12}) begin
            errors++;
            $display("FAIL enter_row: got en=%b cur=%0d, need 0/12", wr_en, cursor);
        end
        send_byte(8'h1C);
        checks++;
        if ({wr_en, wr_addr, cursor} !== {1'b1, 7'd12, 7'd13}) begin
            errors++;
            $display("FAIL after_enter: got en=%b addr=%0d cur=%0d, need 1/12/13", wr_en, wr_addr, cursor);
        end
        send_byte(8'h66);
        checks++;
        if ({wr_en, wr_addr, wr_data, cursor} !== {1'b1, 7'd12, 8'h20, 7'd12}) begin
            errors++;
            $display("FAIL bksp: got en=%b addr=%0d data=%h cur=%0d, need 1/12/20/12", wr_en, wr_addr, wr_data, cursor);
        end
        send_byte(8'h66);
        checks++;
        if ({wr_addr, cursor} !== {7'd11, 7'd11}) begin
            errors++;
            $display("FAIL bksp_row_back: got addr=%0d cur=%0d, need 11/11", wr_addr, cursor);
        end
        send_byte(8'h29);
        checks++;
        if ({wr_addr, wr_data, cursor} !== {7'd11, 8'h20, 7'd12}) begin
            errors++;
            $display("FAIL space: got addr=%0d data=%h cur=%0d, need 11/20/12", wr_addr, wr_data, cursor);
        end
        for (int i = 0; i < 7; i++) send_byte(8'h5A);
        checks++;
        if (cursor !== 7'd96) begin
            errors++;
            $display("FAIL enter_last_row: got cur=%0d, need 96", cursor);
        end
        send_byte(8'h5A);
        checks++;
        if (cursor !== 7'd0) begin
            errors++;
            $display("FAIL enter_wrap: got cur=%0d, need 0", cursor);
        end
    endtask

    task automatic test_clear();
        do_reset();
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'h76);
        for (int i = 0; i < 108; i++) begin
            checks++;
            if ({busy, wr_en, wr_addr, wr_data} !== {1'b1, 1'b1, 7'(i), 8'h20}) begin
                errors++;
                $display("FAIL sweep_cycle%0d: got busy=%b en=%b addr=%0d data=%h, need 1/1/%0d/20",
                         i, busy, wr_en, wr_addr, wr_data, i);
            end
            // Inject a keystroke mid-sweep; it must leave no trace
            rx_data   = 8'h1C;
            read_data = (i == 40);
            @(negedge clk);
        end
        read_data = 1'b0;
        checks++;
        if ({busy, wr_en, cursor, shift_active} !== {1'b0, 1'b0, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL sweep_done: got busy=%b en=%b cur=%0d sh=%b, need 0/0/0/1", busy, wr_en, cursor, shift_active);
        end
        send_byte(8'h1C);
        checks++;
        if ({wr_addr, wr_data} !== {7'd0, 8'h41}) begin
            errors++;
            $display("FAIL after_sweep: got addr=%0d data=%h, need 0/41", wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h76);
        repeat (50) @(negedge clk);
        checks++;
        if ({busy, wr_addr} !== {1'b1, 7'd50}) begin
            errors++;
            $display("FAIL sweep_progress: got busy=%b addr=%0d, need 1/50", busy, wr_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({wr_en, cursor, busy} !== {1'b0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_abort: got en=%b cur=%0d busy=%b, need 0/0/0", wr_en, cursor, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL no_resume: got en=%b busy=%b, need 0/0", wr_en, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_decoder();
        test_wrap();
        test_enter_bksp();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
